// File: rtl/trigger_link_reset_ctrl.sv
// Power-up and relink sequencer for the trigger fiber links: it walks the QPLL, MMCM and GTX TX
// reset chain, waits for every enabled link to lock, and raises links_ready only once status has settled.
module trigger_link_reset_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4000,
    parameter int SETTLE_CYCLES  = 64
) (
    input  logic       clk_40,
    input  logic       reset,
    input  logic       force_relink,
    input  logic [3:0] link_mask,
    input  logic [3:0] tx_pll_locked,
    input  logic       mmcm_locked,
    input  logic [3:0] tx_reset_done,
    input  logic [3:0] tx_sync_done,
    output logic       txpll_rst,
    output logic       mmcm_rst,
    output logic       gtx_tx_rst,
    output logic       trg_rst,
    output logic       links_ready,
    output logic [2:0] state,
    output logic [7:0] retry_count,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        ST_RST          = 3'd0,
        ST_WAIT_PLL     = 3'd1,
        ST_WAIT_MMCM    = 3'd2,
        ST_WAIT_RSTDONE = 3'd3,
        ST_WAIT_SYNC    = 3'd4,
        ST_SETTLE       = 3'd5,
        ST_READY        = 3'd6
    } state_t;

    logic [3:0]  pll_p0, pll_p1;
    logic        mmcm_p0, mmcm_p1;
    logic [3:0]  rdone_p0, rdone_p1;
    logic [3:0]  sync_p0, sync_p1;

    state_t      cur_state, nxt_state;
    logic [15:0] timer;
    logic        retry_inc, timeout_set, entering;
    logic        pll_ok, mmcm_ok, rdone_ok, sync_ok, all_ok, lock_tmo;

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge clk_40) begin
        if (reset) begin
            pll_p0   <= '0;
            pll_p1   <= '0;
            mmcm_p0  <= 1'b0;
            mmcm_p1  <= 1'b0;
            rdone_p0 <= '0;
            rdone_p1 <= '0;
            sync_p0  <= '0;
            sync_p1  <= '0;
        end else begin
            pll_p0   <= tx_pll_locked;
            pll_p1   <= pll_p0;
            mmcm_p0  <= mmcm_locked;
            mmcm_p1  <= mmcm_p0;
            rdone_p0 <= tx_reset_done;
            rdone_p1 <= rdone_p0;
            sync_p0  <= tx_sync_done;
            sync_p1  <= sync_p0;
        end
    end

    // Masked-off links count as good; the mask is used live so changes apply immediately
    assign pll_ok   = &(pll_p1 | ~link_mask);
    assign mmcm_ok  = mmcm_p1;
    assign rdone_ok = &(rdone_p1 | ~link_mask);
    assign sync_ok  = &(sync_p1 | ~link_mask);
    assign all_ok   = pll_ok & mmcm_ok & rdone_ok & sync_ok;
    assign lock_tmo = (timer == 16'(LOCK_TIMEOUT - 1));

    always_comb begin
        nxt_state   = cur_state;
        retry_inc   = 1'b0;
        timeout_set = 1'b0;
        case (cur_state)
            ST_RST:
                if (timer == 16'(PLL_RST_CYCLES - 1)) nxt_state = ST_WAIT_PLL;
            ST_WAIT_PLL:
                if (pll_ok) nxt_state = ST_WAIT_MMCM;
                else if (lock_tmo) begin
                    nxt_state   = ST_RST;
                    retry_inc   = 1'b1;
                    timeout_set = 1'b1;
                end
            ST_WAIT_MMCM:
                if (mmcm_ok) nxt_state = ST_WAIT_RSTDONE;
                else if (lock_tmo) begin
                    nxt_state   = ST_RST;
                    retry_inc   = 1'b1;
                    timeout_set = 1'b1;
                end
            ST_WAIT_RSTDONE:
                if (rdone_ok) nxt_state = ST_WAIT_SYNC;
                else if (lock_tmo) begin
                    nxt_state   = ST_RST;
                    retry_inc   = 1'b1;
                    timeout_set = 1'b1;
                end
            ST_WAIT_SYNC:
                if (sync_ok) nxt_state = ST_SETTLE;
                else if (lock_tmo) begin
                    nxt_state   = ST_RST;
                    retry_inc   = 1'b1;
                    timeout_set = 1'b1;
                end
            ST_SETTLE:
                if (!all_ok) begin
                    nxt_state = ST_RST;
                    retry_inc = 1'b1;
                end else if (timer == 16'(SETTLE_CYCLES - 1)) nxt_state = ST_READY;
            ST_READY:
                if (!(pll_ok && mmcm_ok)) begin
                    nxt_state = ST_RST;
                    retry_inc = 1'b1;
                end
            default:
                nxt_state = ST_RST;
        endcase
        // A manual relink is not a retry and beats every other transition
        if (force_relink) begin
            nxt_state   = ST_RST;
            retry_inc   = 1'b0;
            timeout_set = 1'b0;
        end
    end

    assign entering = (nxt_state != cur_state) || force_relink;

    // Outputs are registered decodes of the next state, so they line up with the state register
    always_ff @(posedge clk_40) begin
        if (reset) begin
            cur_state   <= ST_RST;
            timer       <= '0;
            retry_count <= '0;
            timeout_err <= 1'b0;
            txpll_rst   <= 1'b1;
            mmcm_rst    <= 1'b1;
            gtx_tx_rst  <= 1'b1;
            trg_rst     <= 1'b1;
            links_ready <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            timer       <= entering ? 16'd0 : timer + 16'd1;
            if (retry_inc && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
            if (timeout_set) timeout_err <= 1'b1;
            txpll_rst   <= (nxt_state == ST_RST);
            mmcm_rst    <= (nxt_state == ST_RST) || (nxt_state == ST_WAIT_PLL);
            gtx_tx_rst  <= (nxt_state == ST_RST) || (nxt_state == ST_WAIT_PLL) ||
                           (nxt_state == ST_WAIT_MMCM);
            trg_rst     <= (nxt_state == ST_RST) || (nxt_state == ST_WAIT_PLL) ||
                           (nxt_state == ST_WAIT_MMCM) || (nxt_state == ST_WAIT_RSTDONE);
            links_ready <= (nxt_state == ST_READY);
        end
    end

    assign state = cur_state;

endmodule

// File: doc/trigger_link_reset_ctrl.md
TRIGGER_LINK_RESET_CTRL -- requirements
Module: trigger_link_reset_ctrl

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: cycles the reset outputs are held asserted in RST.
REQ-002 Parameter LOCK_TIMEOUT, default 4000: maximum cycles (100 us) spent in any WAIT_* state.
REQ-003 Parameter SETTLE_CYCLES, default 64: cycles of stable status required before READY.
REQ-004 clk_40  in  1  40 MHz QPLL fabric clock; all logic runs on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 force_relink  in  1  single-cycle request to restart the sequence.
REQ-007 link_mask  in  4  per-link enable; 1 = link participates in lock/done checks.
REQ-008 tx_pll_locked  in  4  per-link GTX TX PLL lock; asynchronous.
REQ-009 mmcm_locked  in  1  usrclk MMCM lock; asynchronous.
REQ-010 tx_reset_done  in  4  per-link GTX TX reset done; asynchronous.
REQ-011 tx_sync_done  in  4  per-link TX phase-align done; asynchronous.
REQ-012 txpll_rst  out  1  GTX TX PLL reset.
REQ-013 mmcm_rst  out  1  MMCM reset.
REQ-014 gtx_tx_rst  out  1  GTX TX datapath reset.
REQ-015 trg_rst  out  1  trigger fiber logic reset.
REQ-016 links_ready  out  1  high only in READY; gates cluster data onto the links.
REQ-017 state  out  3  current state encoding.
REQ-018 retry_count  out  8  saturating count of automatic restarts.
REQ-019 timeout_err  out  1  sticky flag: a WAIT_* timeout occurred.

Function
REQ-020 Each of tx_pll_locked, mmcm_locked, tx_reset_done and tx_sync_done SHALL pass a 2-FF synchronizer; all checks use the synchronized values.
REQ-021 Per-group condition SHALL be AND over bits with link_mask=1 of (signal | ~link_mask); link_mask=0000 makes per-link conditions true; mmcm_locked is always checked.
REQ-022 States and encodings: RST=0, WAIT_PLL=1, WAIT_MMCM=2, WAIT_RSTDONE=3, WAIT_SYNC=4, SETTLE=5, READY=6; codes 7 SHALL recover to RST on the next cycle.
REQ-023 Outputs SHALL be Moore decodes of the state register: txpll_rst=1 in RST only; mmcm_rst=1 in RST and WAIT_PLL; gtx_tx_rst=1 in RST, WAIT_PLL and WAIT_MMCM; trg_rst=1 in all states before WAIT_SYNC; links_ready=1 in READY only.
REQ-024 A single 16-bit timer SHALL clear on every state entry and increment every cycle otherwise.
REQ-025 RST -> WAIT_PLL when timer = PLL_RST_CYCLES-1; RST thus lasts exactly PLL_RST_CYCLES cycles.
REQ-026 WAIT_PLL -> WAIT_MMCM on PLL condition; WAIT_MMCM -> WAIT_RSTDONE on mmcm_locked; WAIT_RSTDONE -> WAIT_SYNC on reset-done condition; WAIT_SYNC -> SETTLE on sync condition; each transition takes effect the cycle after the condition is seen.
REQ-027 In any WAIT_* state, if the condition is false and timer = LOCK_TIMEOUT-1: go to RST, set timeout_err, increment retry_count; the condition SHALL win when both occur in the same cycle.
REQ-028 SETTLE -> READY when timer = SETTLE_CYCLES-1 and all conditions are still true; any condition false in SETTLE -> RST with retry_count increment.
REQ-029 In READY, loss of PLL condition or mmcm_locked SHALL cause RST next cycle with retry_count increment; links_ready drops the same cycle the state leaves READY.
REQ-030 force_relink SHALL send any state to RST next cycle without incrementing retry_count, and SHALL take priority over all other transitions.
REQ-031 retry_count SHALL saturate at 255; timeout_err SHALL clear only on reset.
REQ-032 A link_mask change SHALL take effect in the same cycle it is applied; no restart is implied.

Reset
REQ-033 On reset: state=RST, timer=0, retry_count=0, timeout_err=0, synchronizers=0; txpll_rst=mmcm_rst=gtx_tx_rst=trg_rst=1, links_ready=0.
REQ-034 Reset asserted mid-sequence or in READY SHALL override force_relink and every transition, with the same result as REQ-033.

Verification
REQ-035 Reset release with all status held high and mask=1111 -> READY reached after 16 + 4*(2 sync + 1) + 64 cycles ±1; retry_count=0.
REQ-036 tx_pll_locked[2] held low with mask=1111 -> RST after 4000 cycles in WAIT_PLL; timeout_err=1, retry_count=1; with mask=1011 -> sequence completes.
REQ-037 In READY, mmcm_locked drops for 1 cycle -> after 2-cycle sync latency, links_ready=0 and state=RST; retry_count increments by 1.
REQ-038 force_relink pulse in WAIT_SYNC -> RST next cycle, retry_count unchanged; all resets reassert.
REQ-039 Repeated PLL timeouts (300 iterations, shortened LOCK_TIMEOUT) -> retry_count holds at 255; a subsequent reset clears it to 0.
